// File: rtl/fifo_reader_pkg.sv
// Shared defaults and occupancy encoding for the FIFO reader and its skid buffer.
// The occupancy code equals the number of buffered words.
package fifo_reader_pkg;

    localparam int DATA_WIDTH_DEF = 10;
    localparam int ADDR_WIDTH_DEF = 8;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    function automatic logic [2:0] occ_count(input logic [1:0] occ);
        return {1'b0, occ};
    endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry skid buffer: entry 0 is always the head, entry 1 the second word.
// Holds the occupancy FSM; a capture in TWO cannot occur because the reader never over-issues.
module skid_buffer_2
    import fifo_reader_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture_i,
    input  logic                  deliver_i,
    input  logic [data_width-1:0] wr_data_i,
    output logic [data_width-1:0] head_o,
    output logic                  valid_o,
    output logic [1:0]            occ_o
);

    logic [1:0]            occ_q, occ_d;
    logic [data_width-1:0] mem_q [2];
    logic [data_width-1:0] mem_d [2];

    always_comb begin
        occ_d    = occ_q;
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        case (occ_q)
            OCC_EMPTY: begin
                if (capture_i) begin
                    mem_d[0] = wr_data_i;
                    occ_d    = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({capture_i, deliver_i})
                    2'b10: begin
                        mem_d[1] = wr_data_i;
                        occ_d    = OCC_TWO;
                    end
                    2'b01: occ_d = OCC_EMPTY;
                    // Head leaves while the new word arrives: new word becomes head.
                    2'b11: mem_d[0] = wr_data_i;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                if (deliver_i) begin
                    mem_d[0] = mem_q[1];
                    occ_d    = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= OCC_EMPTY;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head_o  = mem_q[0];
    assign valid_o = (occ_q != OCC_EMPTY);
    assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Pops a registered-output FIFO into a two-entry skid buffer, tracking the word in flight
// so the buffer never overflows, and counts words delivered downstream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH_DEF,
    parameter int address_width = ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     fifo_empty,
    input  logic [data_width-1:0]    FIFO_data_out,
    output logic                     pop,
    input  logic                     pause,
    output logic [data_width-1:0]    data_out,
    output logic                     valid_out,
    output logic [address_width-1:0] words_read
);

    logic                     inflight_q, inflight_d;
    logic [address_width-1:0] words_read_q, words_read_d;
    logic                     deliver;
    logic [1:0]               occ;
    logic [2:0]               load;
    logic                     room;

    skid_buffer_2 #(
        .data_width(data_width)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .capture_i (inflight_q),
        .deliver_i (deliver),
        .wr_data_i (FIFO_data_out),
        .head_o    (data_out),
        .valid_o   (valid_out),
        .occ_o     (occ)
    );

    assign deliver = valid_out & ~pause;

    // Committed words (buffered + in flight) after this cycle's delivery must stay below two.
    assign load = occ_count(occ) + {2'b00, inflight_q};
    assign room = load < (3'd2 + {2'b00, deliver});
    assign pop  = ~reset & enable & ~fifo_empty & room;

    assign inflight_d   = pop;
    assign words_read_d = words_read_q + {{(address_width-1){1'b0}}, deliver};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q   <= 1'b0;
            words_read_q <= '0;
        end else begin
            inflight_q   <= inflight_d;
            words_read_q <= words_read_d;
        end
    end

    assign words_read = words_read_q;

endmodule
